mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one structural 4:1 bit multiplexer between four requesters. It grants one requester at a time and drives the mux select from the grant. It enforces a bounded hold time so no requester can starve the others. The selected data bit is registered and presented with a valid flag to the downstream logic.

---
 rtl/mux4_rr_arbiter_pkg.sv | 26 ++
 rtl/MUX_estrutural.sv | 22 ++
 rtl/mux4_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin mux arbiter:
// state encoding, requester/select sizing and a one-hot helper.
package mux4_rr_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic logic [NREQ-1:0] sel2onehot(input logic [SEL_W-1:0] sel);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/MUX_estrutural.sv
// Gate-level 4:1 single-bit multiplexer: Y = D[S].
module MUX_estrutural (
  input  logic [3:0] D,
  input  logic [1:0] S,
  output logic       Y
);

  logic       s0_n;
  logic       s1_n;
  logic [3:0] term;

  not u_n0 (s0_n, S[0]);
  not u_n1 (s1_n, S[1]);

  and u_a0 (term[0], D[0], s1_n, s0_n);
  and u_a1 (term[1], D[1], s1_n, S[0]);
  and u_a2 (term[2], D[2], S[1], s0_n);
  and u_a3 (term[3], D[3], S[1], S[0]);

  or  u_o  (Y, term[0], term[1], term[2], term[3]);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded hold time that drives the select of a
// shared structural 4:1 bit mux and registers the selected bit with a valid.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ-1:0]  D,
  output logic [NREQ-1:0]  GNT,
  output logic [SEL_W-1:0] S,
  output logic             Y,
  output logic             VALID
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(HOLD_MAX - 1);

  arb_state_e       state_p0;
  arb_state_e       state_nx;
  logic [SEL_W-1:0] last_p0;
  logic [SEL_W-1:0] last_nx;
  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_nx;
  logic [NREQ-1:0]  gnt_nx;
  logic [SEL_W-1:0] sel_nx;
  pick_t            pick_any;
  pick_t            pick_other;
  logic             mux_y;

  // Scan base+1, base+2, base+3, base; first requesting index wins.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                    input logic [SEL_W-1:0] base);
    pick_t            p;
    logic [SEL_W-1:0] idx;
    p = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = base + SEL_W'(k);
      if (!p.found && req[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

  // While granted, last_p0 is the holder, so masking it gives "others only".
  assign pick_any   = rr_pick(REQ, last_p0);
  assign pick_other = rr_pick(REQ & ~sel2onehot(last_p0), last_p0);

  MUX_estrutural u_mux (
    .D (D),
    .S (S),
    .Y (mux_y)
  );

  // Stage p0: arbitration state and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_p0 <= ST_IDLE;
      last_p0  <= '1;
      cnt_p0   <= '0;
      GNT      <= '0;
      S        <= '0;
      Y        <= 1'b0;
      VALID    <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      last_p0  <= last_nx;
      cnt_p0   <= cnt_nx;
      GNT      <= gnt_nx;
      S        <= sel_nx;
      Y        <= mux_y;
      VALID    <= (state_p0 == ST_GRANT);
    end
  end

  always_comb begin
    state_nx = state_p0;
    last_nx  = last_p0;
    cnt_nx   = cnt_p0;
    unique case (state_p0)
      ST_IDLE: begin
        if (pick_any.found) begin
          state_nx = ST_GRANT;
          last_nx  = pick_any.idx;
          cnt_nx   = '0;
        end
      end
      ST_GRANT: begin
        if (!REQ[last_p0]) begin
          cnt_nx = '0;
          if (pick_any.found) begin
            last_nx = pick_any.idx;
          end else begin
            state_nx = ST_IDLE;
          end
        end else if (cnt_p0 != CNT_TOP) begin
          cnt_nx = cnt_p0 + 1'b1;
        end else begin
          // Timeout: hand over if anyone else waits, otherwise regrant.
          cnt_nx = '0;
          if (pick_other.found) begin
            last_nx = pick_other.idx;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Select holds its last value while idle.
  always_comb begin
    gnt_nx = '0;
    sel_nx = S;
    if (state_nx == ST_GRANT) begin
      gnt_nx = sel2onehot(last_nx);
      sel_nx = last_nx;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: four instances (HOLD_MAX 8,2,4,1) sharing stimulus,
// a vector table, hand-written corner sequences and a random run vs. a model.
module tb_mux4_rr_arbiter;

  logic       CLK;
  logic       RST;
  logic [3:0] REQ;
  logic [3:0] D;

  logic [3:0] gnt [4];
  logic [1:0] sel [4];
  logic       y   [4];
  logic       vld [4];

  int holds [4] = '{8, 2, 4, 1};

  int errors = 0;
  int checks = 0;

  mux4_rr_arbiter #(.HOLD_MAX(8)) u_h8 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .D(D),
    .GNT(gnt[0]), .S(sel[0]), .Y(y[0]), .VALID(vld[0]));
  mux4_rr_arbiter #(.HOLD_MAX(2)) u_h2 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .D(D),
    .GNT(gnt[1]), .S(sel[1]), .Y(y[1]), .VALID(vld[1]));
  mux4_rr_arbiter #(.HOLD_MAX(4)) u_h4 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .D(D),
    .GNT(gnt[2]), .S(sel[2]), .Y(y[2]), .VALID(vld[2]));
  mux4_rr_arbiter #(.HOLD_MAX(1)) u_h1 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .D(D),
    .GNT(gnt[3]), .S(sel[3]), .Y(y[3]), .VALID(vld[3]));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: owner (-1 = nobody), cycles held so far (1-based), last winner.
  int   m_owner [4];
  int   m_held  [4];
  int   m_last  [4];
  int   m_s     [4];
  logic m_y     [4];
  logic m_v     [4];

  function automatic int next_winner(logic [3:0] r, int from, int excl);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (from + k) % 4;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_owner[i] = -1;
      m_held[i]  = 0;
      m_last[i]  = 3;
      m_s[i]     = 0;
      m_y[i]     = 1'b0;
      m_v[i]     = 1'b0;
    end
  endtask

  task automatic model_step(int i);
    int w;
    m_y[i] = D[m_s[i]];
    m_v[i] = (m_owner[i] >= 0);
    if (m_owner[i] < 0 || !REQ[m_owner[i]]) begin
      w = next_winner(REQ, m_last[i], -1);
      m_owner[i] = w;
      if (w >= 0) begin
        m_last[i] = w;
        m_held[i] = 1;
      end
    end else if (m_held[i] < holds[i]) begin
      m_held[i]++;
    end else begin
      w = next_winner(REQ, m_last[i], m_owner[i]);
      if (w >= 0) begin
        m_owner[i] = w;
        m_last[i]  = w;
      end
      m_held[i] = 1;
    end
    if (m_owner[i] >= 0) m_s[i] = m_owner[i];
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model gnt h%0d", holds[i]), int'(gnt[i]),
          (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0);
      chk($sformatf("model sel h%0d", holds[i]), int'(sel[i]), m_s[i]);
      chk($sformatf("model valid h%0d", holds[i]), int'(vld[i]), int'(m_v[i]));
      if (m_v[i]) chk($sformatf("model y h%0d", holds[i]), int'(y[i]), int'(m_y[i]));
    end
  endtask

  // Advance one clock; inputs stay stable across the edge, outputs sampled 1ns after.
  task automatic tick();
    for (int i = 0; i < 4; i++) model_step(i);
    @(posedge CLK);
    #1;
    compare_model();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    #2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset gnt h%0d", holds[i]), int'(gnt[i]), 0);
      chk($sformatf("reset sel h%0d", holds[i]), int'(sel[i]), 0);
      chk($sformatf("reset y h%0d", holds[i]), int'(y[i]), 0);
      chk($sformatf("reset valid h%0d", holds[i]), int'(vld[i]), 0);
    end
    RST = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       y;
    logic       v;
    logic       chk_y;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Full contention on HOLD_MAX=2 with D=0110, then drain to idle.
    tbl[0]  = '{4'b1111, 4'b0110, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 4'b0110, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{4'b1111, 4'b0110, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{4'b1111, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{4'b1111, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{4'b1111, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{4'b1111, 4'b0110, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{4'b1111, 4'b0110, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{4'b1111, 4'b0110, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0110, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{4'b0000, 4'b0110, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};

    RST = 1'b1;
    REQ = 4'b0000;
    D   = 4'b0000;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    for (int v = 0; v < 11; v++) begin
      REQ = tbl[v].req;
      D   = tbl[v].d;
      tick();
      chk($sformatf("tbl%0d gnt", v), int'(gnt[1]), int'(tbl[v].gnt));
      chk($sformatf("tbl%0d sel", v), int'(sel[1]), int'(tbl[v].s));
      chk($sformatf("tbl%0d valid", v), int'(vld[1]), int'(tbl[v].v));
      if (tbl[v].chk_y) chk($sformatf("tbl%0d y", v), int'(y[1]), int'(tbl[v].y));
    end

    // Single request: grant after first edge, data after second.
    do_reset();
    REQ = 4'b0001;
    D   = 4'b0001;
    tick();
    chk("single gnt", int'(gnt[0]), 4'b0001);
    chk("single sel", int'(sel[0]), 0);
    chk("single valid0", int'(vld[0]), 0);
    tick();
    chk("single y", int'(y[0]), 1);
    chk("single valid1", int'(vld[0]), 1);

    // Reset mid-grant with requester 2 granted, then requester 0 has priority.
    do_reset();
    REQ = 4'b0100;
    D   = 4'b1111;
    tick();
    tick();
    chk("pre-reset gnt", int'(gnt[0]), 4'b0100);
    chk("pre-reset valid", int'(vld[0]), 1);
    do_reset();
    REQ = 4'b1111;
    tick();
    chk("post-reset gnt", int'(gnt[0]), 4'b0001);

    // Early release: 0 drops after three granted cycles, handover without a bubble.
    do_reset();
    REQ = 4'b0101;
    D   = 4'b0101;
    tick();
    chk("early gnt c1", int'(gnt[0]), 4'b0001);
    for (int c = 2; c <= 3; c++) begin
      tick();
      chk($sformatf("early gnt c%0d", c), int'(gnt[0]), 4'b0001);
      chk($sformatf("early valid c%0d", c), int'(vld[0]), 1);
    end
    REQ = 4'b0100;
    tick();
    chk("early handover gnt", int'(gnt[0]), 4'b0100);
    chk("early handover valid", int'(vld[0]), 1);
    tick();
    chk("early after valid", int'(vld[0]), 1);
    chk("early after y", int'(y[0]), 1);

    // Lone holder past timeout on HOLD_MAX=4.
    do_reset();
    REQ = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("lone gnt c%0d", c), int'(gnt[2]), 4'b1000);
    end

    // Drain: requester 1 releases, select parks at 01.
    do_reset();
    REQ = 4'b0010;
    tick();
    tick();
    REQ = 4'b0000;
    tick();
    chk("drain gnt", int'(gnt[0]), 4'b0000);
    chk("drain valid0", int'(vld[0]), 1);
    chk("drain sel0", int'(sel[0]), 1);
    tick();
    chk("drain valid1", int'(vld[0]), 0);
    chk("drain sel1", int'(sel[0]), 1);

    // Random traffic with sticky requests so holds and timeouts occur.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3, 0) == 0) REQ = 4'($urandom);
      D = 4'($urandom);
      if ($urandom_range(79, 0) == 0) do_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
